qpu_exu_lsu_ctrl: RTL and testbench
===================================

Name: qpu_exu_lsu_ctrl

Overview:
- Second-generation QPU load/store unit. Issue interface from the EXU, address generation shared with the ALU, ICB master port to memory.
- Generalises the first-generation LSU: byte/half/word accesses with wmask/wdata alignment, configurable multiple outstanding transactions, and a real response path.
- Response path covers load data extraction, sign/zero extension, write-back of rd, and misalignment/bus-error reporting to commit.

Parameters:
- XLEN, 32, data width; only 32 is supported; wmask width XLEN/8.
- ADDR_W, 16, ICB address width (low bits of ALU result).
- OUTS_DEPTH, 2, max outstanding ICB transactions (power of 2, >=1).
- RDIDX_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lsu_i_valid  in  1  issue valid
- lsu_i_ready  out  1  issue ready
- lsu_i_rs1  in  XLEN  base operand
- lsu_i_rs2  in  XLEN  store data
- lsu_i_imm  in  XLEN  offset
- lsu_i_load  in  1  load op
- lsu_i_store  in  1  store op
- lsu_i_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- lsu_i_usign  in  1  zero-extend load
- lsu_i_rdidx  in  RDIDX_W  load destination
- lsu_o_valid  out  1  write-back/commit valid
- lsu_o_ready  in  1  write-back ready
- lsu_o_wbck_wdat  out  XLEN  load result (0 for store/error)
- lsu_o_rdidx  out  RDIDX_W  destination index
- lsu_o_rdwen  out  1  register write enable
- lsu_o_misalgn  out  1  misaligned-access exception
- lsu_o_buserr  out  1  bus-error exception
- lsu_icb_cmd_valid  out  1  ICB cmd valid
- lsu_icb_cmd_ready  in  1  ICB cmd ready
- lsu_icb_cmd_addr  out  ADDR_W  ICB cmd address
- lsu_icb_cmd_read  out  1  ICB cmd read
- lsu_icb_cmd_wdata  out  XLEN  ICB cmd write data
- lsu_icb_cmd_wmask  out  XLEN/8  ICB cmd write mask
- lsu_icb_rsp_valid  in  1  ICB rsp valid
- lsu_icb_rsp_ready  out  1  ICB rsp ready
- lsu_icb_rsp_rdata  in  XLEN  ICB rsp read data
- lsu_icb_rsp_err  in  1  ICB rsp error
- lsu_req_alu_op1  out  XLEN  = rs1
- lsu_req_alu_op2  out  XLEN  = imm
- lsu_req_alu_res  in  XLEN  ALU sum

Behaviour:
- addr = lsu_req_alu_res[ADDR_W-1:0]; ldst = load|store.
- misalgn = (half & addr[0]) | (word & addr[1:0]!=0).
- Outstanding FIFO, OUTS_DEPTH entries of {load, size, usign, rdidx, addr[1:0]}. Push on cmd handshake, pop on rsp handshake. Simultaneous push+pop: count unchanged. Reset: empty.
- Aligned op:
  - cmd_valid = i_valid & ldst & ~misalgn & ~fifo_full & ~exc_vld.
  - i_ready = cmd_ready & ~fifo_full & ~exc_vld.
  - Zero added latency, cmd is combinational from issue.
- Misaligned op:
  - Never sent to ICB.
  - Accepted (i_ready=1) only when fifo empty and ~exc_vld.
  - Captured into a one-entry exception register: exc_vld set the next cycle, cleared on o_valid&o_ready.
  - This preserves program order of commits.
- Non-ldst issue with i_valid: i_ready=1, dropped, no side effects.
- Store data and mask:
  - byte: wdata={4{rs2[7:0]}}, wmask=4'b0001<<addr[1:0].
  - half: wdata={2{rs2[15:0]}}, wmask=4'b0011<<addr[1:0].
  - word: wdata=rs2, wmask=4'b1111.
  - Loads: wmask=0.
- Write-back:
  - lsu_o_valid = exc_vld | (rsp_valid & ~fifo_empty).
  - rsp_ready = lsu_o_ready & ~fifo_empty. rsp_valid on an empty FIFO is never accepted.
- Load result, using the head entry:
  - data = rdata >> (8*head.addr[1:0]).
  - byte/half: sign- or zero-extend per usign.
  - rdwen = head.load & ~rsp_err.
  - wbck_wdat = 0 when rdwen=0.
- buserr = rsp_err of the popped response. misalgn = exc_vld. rdwen=0 on any exception.
- Reset, asynchronous on rst_n low: FIFO pointers/count=0, exc_vld=0.
  - Hence o_valid=0, cmd_valid=0 and rsp_ready=0 while in reset and on the first cycle after release.
  - Any outstanding transactions are discarded on reset mid-operation.

Optional Feature:
- QPU_LSU_MISALGN_CHK_EN defined: misalignment detection and exception path as above.
- Undefined: misalgn forced 0, lsu_o_misalgn tied 0, exception register removed.
  - cmd_addr has low bits cleared to size alignment (half: addr[0]=0; word: addr[1:0]=0).
  - Extraction/wmask use the cleared address.

Test Plan:
- Word store rs1=0x100, imm=4, rs2=0xDEADBEEF, cmd_ready=1 -> same-cycle cmd addr=0x104, read=0, wmask=4'b1111, wdata=0xDEADBEEF. Rsp next cycle -> o_valid=1, rdwen=0.
- Byte load addr=0x103, usign=0, rdata=0x80FF_0000 -> wbck_wdat=0xFFFF_FF80, rdwen=1, rdidx echoed. Same access with usign=1 -> 0x0000_0080.
- OUTS_DEPTH=2, three back-to-back aligned loads, rsp held low -> two cmds accepted, i_ready=0 on third. One rsp -> third issues in the same cycle as the pop; responses return in order.
- Half store addr=0x0001 with QPU_LSU_MISALGN_CHK_EN -> no ICB cmd; o_valid next cycle with misalgn=1, rdwen=0. Misaligned op while FIFO non-empty -> i_ready=0 until drained.
- Load rsp with rsp_err=1 -> buserr=1, rdwen=0, wbck_wdat=0. lsu_o_ready=0 -> rsp_ready=0 and the response held.
- rst_n pulsed low with 2 outstanding -> o_valid=0, FIFO empty, cmd_valid=0; next issue accepted normally.

Source files
------------

// File: rtl/qpu_exu_lsu_ctrl.sv
// QPU load/store unit: EXU issue, shared-ALU address generation, in-order outstanding ICB traffic.
// Optional macro QPU_LSU_MISALGN_CHK_EN traps misaligned accesses instead of aligning them down.
module qpu_exu_lsu_ctrl #(
   parameter int XLEN       = 32,
   parameter int ADDR_W     = 16,
   parameter int OUTS_DEPTH = 2,
   parameter int RDIDX_W    = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               lsu_i_valid,
   output logic               lsu_i_ready,
   input  logic [XLEN-1:0]    lsu_i_rs1,
   input  logic [XLEN-1:0]    lsu_i_rs2,
   input  logic [XLEN-1:0]    lsu_i_imm,
   input  logic               lsu_i_load,
   input  logic               lsu_i_store,
   input  logic [1:0]         lsu_i_size,
   input  logic               lsu_i_usign,
   input  logic [RDIDX_W-1:0] lsu_i_rdidx,
   output logic               lsu_o_valid,
   input  logic               lsu_o_ready,
   output logic [XLEN-1:0]    lsu_o_wbck_wdat,
   output logic [RDIDX_W-1:0] lsu_o_rdidx,
   output logic               lsu_o_rdwen,
   output logic               lsu_o_misalgn,
   output logic               lsu_o_buserr,
   output logic               lsu_icb_cmd_valid,
   input  logic               lsu_icb_cmd_ready,
   output logic [ADDR_W-1:0]  lsu_icb_cmd_addr,
   output logic               lsu_icb_cmd_read,
   output logic [XLEN-1:0]    lsu_icb_cmd_wdata,
   output logic [XLEN/8-1:0]  lsu_icb_cmd_wmask,
   input  logic               lsu_icb_rsp_valid,
   output logic               lsu_icb_rsp_ready,
   input  logic [XLEN-1:0]    lsu_icb_rsp_rdata,
   input  logic               lsu_icb_rsp_err,
   output logic [XLEN-1:0]    lsu_req_alu_op1,
   output logic [XLEN-1:0]    lsu_req_alu_op2,
   input  logic [XLEN-1:0]    lsu_req_alu_res
);
   localparam int MASK_W = XLEN / 8;
   localparam int PTR_W  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
   localparam int CNT_W  = $clog2(OUTS_DEPTH + 1);
   localparam int ENT_W  = RDIDX_W + 6;

   function automatic logic [XLEN-1:0] ld_extend(input logic [XLEN-1:0] data,
                                                 input logic [1:0] size, input logic usign);
      logic [XLEN-1:0] r;
      case (size)
         2'b00:   r = usign ? {{(XLEN-8){1'b0}}, data[7:0]}   : {{(XLEN-8){data[7]}}, data[7:0]};
         2'b01:   r = usign ? {{(XLEN-16){1'b0}}, data[15:0]} : {{(XLEN-16){data[15]}}, data[15:0]};
         default: r = data;
      endcase
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [ADDR_W-1:0]  addr_raw, addr_eff;
   logic               is_ldst, is_half, is_word, misalgn, exc_vld;
   logic               active_q;
   logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ENT_W-1:0]   fifo_mem [OUTS_DEPTH];
   logic               fifo_empty, fifo_full, push, pop, rsp_vld;
   logic               hd_load, hd_usign;
   logic [1:0]         hd_size, hd_off;
   logic [RDIDX_W-1:0] hd_rdidx;
   logic [XLEN-1:0]    hd_data;
   logic               unused_alu_hi;

   assign lsu_req_alu_op1 = lsu_i_rs1;
   assign lsu_req_alu_op2 = lsu_i_imm;
   assign addr_raw        = lsu_req_alu_res[ADDR_W-1:0];
   assign unused_alu_hi   = ^lsu_req_alu_res[XLEN-1:ADDR_W];
   assign is_ldst         = lsu_i_load | lsu_i_store;
   assign is_half         = (lsu_i_size == 2'b01);
   assign is_word         = lsu_i_size[1];

`ifdef QPU_LSU_MISALGN_CHK_EN
   logic               exc_vld_q, exc_take;
   logic [RDIDX_W-1:0] exc_rdidx_q;

   assign misalgn  = (is_half & addr_raw[0]) | (is_word & (addr_raw[1:0] != 2'b00));
   assign addr_eff = addr_raw;
   assign exc_vld  = exc_vld_q;
   assign exc_take = lsu_i_valid & lsu_i_ready & is_ldst & misalgn;

   // Misaligned ops only enter with an empty FIFO, so commit order is preserved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_vld_q <= 1'b0;
      end else if (exc_take) begin
         exc_vld_q <= 1'b1;
      end else if (lsu_o_valid & lsu_o_ready) begin
         exc_vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (exc_take) exc_rdidx_q <= lsu_i_rdidx;
   end

   assign lsu_o_rdidx = exc_vld_q ? exc_rdidx_q : hd_rdidx;
`else
   assign misalgn     = 1'b0;
   assign exc_vld     = 1'b0;
   assign addr_eff    = {addr_raw[ADDR_W-1:2], addr_raw[1] & ~is_word,
                         addr_raw[0] & ~is_half & ~is_word};
   assign lsu_o_rdidx = hd_rdidx;
`endif

   assign fifo_empty = (cnt_q == '0);
   assign lsu_icb_rsp_ready = lsu_o_ready & ~fifo_empty;
   assign pop        = lsu_icb_rsp_valid & lsu_icb_rsp_ready;
   // A pop in the same cycle frees the slot, letting a new command issue alongside it.
   assign fifo_full  = (cnt_q == CNT_W'(OUTS_DEPTH)) & ~pop;

   assign lsu_icb_cmd_valid = active_q & lsu_i_valid & is_ldst & ~misalgn & ~fifo_full & ~exc_vld;
   assign lsu_i_ready = ~active_q ? 1'b0 :
                        ~is_ldst  ? 1'b1 :
                        misalgn   ? (fifo_empty & ~exc_vld) :
                                    (lsu_icb_cmd_ready & ~fifo_full & ~exc_vld);
   assign push = lsu_icb_cmd_valid & lsu_icb_cmd_ready;

   assign lsu_icb_cmd_addr = addr_eff;
   assign lsu_icb_cmd_read = lsu_i_load;

   always_comb begin
      lsu_icb_cmd_wdata = lsu_i_rs2;
      lsu_icb_cmd_wmask = '1;
      case (lsu_i_size)
         2'b00: begin
            lsu_icb_cmd_wdata = {(XLEN/8){lsu_i_rs2[7:0]}};
            lsu_icb_cmd_wmask = MASK_W'(4'b0001) << addr_eff[1:0];
         end
         2'b01: begin
            lsu_icb_cmd_wdata = {(XLEN/16){lsu_i_rs2[15:0]}};
            lsu_icb_cmd_wmask = MASK_W'(4'b0011) << addr_eff[1:0];
         end
         default: ;
      endcase
      if (lsu_i_load) lsu_icb_cmd_wmask = '0;
   end

   always_comb begin
      wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
      end else begin
         active_q <= 1'b1;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr_q] <= {lsu_i_load, lsu_i_size, lsu_i_usign, lsu_i_rdidx, addr_eff[1:0]};
   end

   assign {hd_load, hd_size, hd_usign, hd_rdidx, hd_off} = fifo_mem[rptr_q];
   assign hd_data = lsu_icb_rsp_rdata >> {hd_off, 3'b000};
   assign rsp_vld = lsu_icb_rsp_valid & ~fifo_empty & ~exc_vld;

   assign lsu_o_valid     = exc_vld | (lsu_icb_rsp_valid & ~fifo_empty);
   assign lsu_o_rdwen     = rsp_vld & hd_load & ~lsu_icb_rsp_err;
   assign lsu_o_wbck_wdat = lsu_o_rdwen ? ld_extend(hd_data, hd_size, hd_usign) : '0;
   assign lsu_o_buserr    = rsp_vld & lsu_icb_rsp_err;
   assign lsu_o_misalgn   = exc_vld;
endmodule

// File: tb/tb_qpu_exu_lsu_ctrl.sv
// Bench for qpu_exu_lsu_ctrl: directed steps, then random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_qpu_exu_lsu_ctrl;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_valid, i_ready, i_load, i_store, i_usign;
   logic [31:0] i_rs1, i_rs2, i_imm;
   logic [1:0]  i_size;
   logic [4:0]  i_rdidx, o_rdidx;
   logic        o_valid, o_ready, o_rdwen, o_misalgn, o_buserr;
   logic [31:0] o_wdat;
   logic        cmd_valid, cmd_ready, cmd_read;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wmask;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata, alu_op1, alu_op2, alu_res;

   qpu_exu_lsu_ctrl #(.XLEN(32), .ADDR_W(16), .OUTS_DEPTH(DEPTH), .RDIDX_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_i_valid(i_valid), .lsu_i_ready(i_ready), .lsu_i_rs1(i_rs1), .lsu_i_rs2(i_rs2),
      .lsu_i_imm(i_imm), .lsu_i_load(i_load), .lsu_i_store(i_store), .lsu_i_size(i_size),
      .lsu_i_usign(i_usign), .lsu_i_rdidx(i_rdidx),
      .lsu_o_valid(o_valid), .lsu_o_ready(o_ready), .lsu_o_wbck_wdat(o_wdat), .lsu_o_rdidx(o_rdidx),
      .lsu_o_rdwen(o_rdwen), .lsu_o_misalgn(o_misalgn), .lsu_o_buserr(o_buserr),
      .lsu_icb_cmd_valid(cmd_valid), .lsu_icb_cmd_ready(cmd_ready), .lsu_icb_cmd_addr(cmd_addr),
      .lsu_icb_cmd_read(cmd_read), .lsu_icb_cmd_wdata(cmd_wdata), .lsu_icb_cmd_wmask(cmd_wmask),
      .lsu_icb_rsp_valid(rsp_valid), .lsu_icb_rsp_ready(rsp_ready), .lsu_icb_rsp_rdata(rsp_rdata),
      .lsu_icb_rsp_err(rsp_err),
      .lsu_req_alu_op1(alu_op1), .lsu_req_alu_op2(alu_op2), .lsu_req_alu_res(alu_res)
   );

   always #5 clk = ~clk;
   assign alu_res = alu_op1 + alu_op2;

   int checks = 0;
   int errors = 0;

   typedef struct { bit load; int n; bit usign; logic [4:0] rd; int off; } txn_t;
   txn_t q[$];
   bit   exc_p;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit m_misal(input int a, input int n);
`ifdef QPU_LSU_MISALGN_CHK_EN
      return (a % n) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int m_addr(input int a, input int n);
`ifdef QPU_LSU_MISALGN_CHK_EN
      return a;
`else
      return a - (a % n);
`endif
   endfunction

   function automatic logic [3:0] m_wmask(input int n, input int off);
      return 4'(((1 << n) - 1) << off);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input int n);
      if (n == 1) return 32'(rs2[7:0]) * 32'h0101_0101;
      if (n == 2) return 32'(rs2[15:0]) * 32'h0001_0001;
      return rs2;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] rdata, input int off, input int n, input bit us);
      longint v, lim;
      lim = longint'(1) << (8 * n);
      v = longint'(rdata >> (8 * off)) % lim;
      if (!us && n < 4 && v >= lim / 2) v = v - lim;
      return v[31:0];
   endfunction

   task automatic idle();
      i_valid = 0; i_load = 0; i_store = 0; i_size = 0; i_usign = 0;
      i_rs1 = 0; i_rs2 = 0; i_imm = 0; i_rdidx = 0;
      cmd_ready = 1; o_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0;
   endtask

   task automatic issue(input bit ld, input bit st, input logic [1:0] sz, input bit us,
                        input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                        input logic [4:0] rd);
      i_valid = 1; i_load = ld; i_store = st; i_size = sz; i_usign = us;
      i_rs1 = rs1; i_imm = imm; i_rs2 = rs2; i_rdidx = rd;
   endtask

   task automatic respond(input logic [31:0] rdata, input bit err);
      rsp_valid = 1; rsp_rdata = rdata; rsp_err = err;
   endtask

   initial begin
      int op, n, a, off;
      bit v, ldst, misal, pop, full_eff, exp_irdy, exp_cv, exp_ov, rdw;
      logic [1:0]  sz;
      logic [31:0] rs1, imm, rs2, rdata;
      logic [4:0]  rd;
      bit us, cr, rv, er, ordy;
      txn_t t;

      idle();
      issue(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'h0, 5'd1);
      respond(32'h0, 0);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_o_valid", o_valid, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_rsp_ready", rsp_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_cmd_valid", cmd_valid, 0);
      chk("rel_o_valid", o_valid, 0);
      chk("rel_rsp_ready", rsp_ready, 0);

      // Non-load/store issue is dropped
      @(negedge clk); idle();
      issue(0, 0, 2'd2, 0, 32'h100, 32'h4, 32'h55, 5'd3);
      respond(32'h1234, 0);
      #1;
      chk("nonldst_i_ready", i_ready, 1);
      chk("nonldst_cmd_valid", cmd_valid, 0);
      chk("nonldst_o_valid", o_valid, 0);
      @(negedge clk); idle(); respond(32'h1234, 0); #1;
      chk("nonldst_nofx_o_valid", o_valid, 0);
      chk("nonldst_nofx_rsp_ready", rsp_ready, 0);

      // Word store
      @(negedge clk); idle();
      issue(0, 1, 2'd2, 0, 32'h100, 32'h4, 32'hDEAD_BEEF, 5'd0);
      #1;
      chk("wst_cmd_valid", cmd_valid, 1);
      chk("wst_i_ready", i_ready, 1);
      chk("wst_addr", cmd_addr, 32'h104);
      chk("wst_read", cmd_read, 0);
      chk("wst_wmask", cmd_wmask, 32'hF);
      chk("wst_wdata", cmd_wdata, 32'hDEAD_BEEF);
      @(negedge clk); idle(); respond(32'h1234_5678, 0); #1;
      chk("wst_o_valid", o_valid, 1);
      chk("wst_rdwen", o_rdwen, 0);
      chk("wst_wdat", o_wdat, 0);
      chk("wst_buserr", o_buserr, 0);
      chk("wst_rsp_ready", rsp_ready, 1);
      @(negedge clk); idle(); respond(32'h1234_5678, 0); #1;
      chk("wst_drained", o_valid, 0);

      // Byte load, signed then unsigned
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); idle();
         issue(1, 0, 2'd0, k[0], 32'h100, 32'h3, 32'h0, (k == 0) ? 5'd7 : 5'd9);
         #1;
         chk("lb_addr", cmd_addr, 32'h103);
         chk("lb_read", cmd_read, 1);
         chk("lb_wmask", cmd_wmask, 0);
         chk("lb_cmd_valid", cmd_valid, 1);
         @(negedge clk); idle(); respond(32'h80FF_0000, 0); #1;
         chk("lb_o_valid", o_valid, 1);
         chk("lb_wdat", o_wdat, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         chk("lb_rdwen", o_rdwen, 1);
         chk("lb_rdidx", o_rdidx, (k == 0) ? 32'd7 : 32'd9);
      end

      // Outstanding limit, pop and push in the same cycle, in-order responses
      @(negedge clk); idle();
      issue(1, 0, 2'd2, 0, 32'h200, 32'h0, 32'h0, 5'd1); #1;
      chk("outs_a_i_ready", i_ready, 1);
      @(negedge clk); idle();
      issue(1, 0, 2'd1, 1, 32'h200, 32'h6, 32'h0, 5'd2); #1;
      chk("outs_b_i_ready", i_ready, 1);
      @(negedge clk); idle();
      issue(1, 0, 2'd0, 0, 32'h200, 32'h1, 32'h0, 5'd3); #1;
      chk("outs_c_blocked_i_ready", i_ready, 0);
      chk("outs_c_blocked_cmd_valid", cmd_valid, 0);
      @(negedge clk);
      respond(32'hA1B2_C3D4, 0); #1;
      chk("outs_a_o_valid", o_valid, 1);
      chk("outs_a_wdat", o_wdat, 32'hA1B2_C3D4);
      chk("outs_a_rdidx", o_rdidx, 1);
      chk("outs_c_i_ready", i_ready, 1);
      chk("outs_c_cmd_valid", cmd_valid, 1);
      chk("outs_c_addr", cmd_addr, 32'h201);
      @(negedge clk); idle(); respond(32'h8001_7FFF, 0); #1;
      chk("outs_b_wdat", o_wdat, 32'h0000_8001);
      chk("outs_b_rdidx", o_rdidx, 2);
      @(negedge clk); idle(); respond(32'h0000_F100, 0); #1;
      chk("outs_c_wdat", o_wdat, 32'hFFFF_FFF1);
      chk("outs_c_rdidx", o_rdidx, 3);
      @(negedge clk); idle(); respond(32'h0, 0); #1;
      chk("outs_drained", o_valid, 0);

`ifdef QPU_LSU_MISALGN_CHK_EN
      @(negedge clk); idle();
      issue(0, 1, 2'd1, 0, 32'h0, 32'h1, 32'h1234_ABCD, 5'd6); #1;
      chk("mis_cmd_valid", cmd_valid, 0);
      chk("mis_i_ready", i_ready, 1);
      @(negedge clk); idle();
      issue(1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h0, 5'd6); o_ready = 0; #1;
      chk("mis_o_valid", o_valid, 1);
      chk("mis_misalgn", o_misalgn, 1);
      chk("mis_rdwen", o_rdwen, 0);
      chk("mis_block_i_ready", i_ready, 0);
      chk("mis_block_cmd_valid", cmd_valid, 0);
      @(negedge clk); idle(); #1;
      chk("mis_held_o_valid", o_valid, 1);
      @(negedge clk); idle(); #1;
      chk("mis_done", o_valid, 0);
      @(negedge clk); idle();
      issue(1, 0, 2'd2, 0, 32'h600, 32'h0, 32'h0, 5'd4); #1;
      chk("misq_a_i_ready", i_ready, 1);
      @(negedge clk); idle();
      issue(1, 0, 2'd2, 0, 32'h100, 32'h2, 32'h0, 5'd5); #1;
      chk("misq_wait_i_ready", i_ready, 0);
      chk("misq_wait_cmd_valid", cmd_valid, 0);
      @(negedge clk); respond(32'h7777_0000, 0); #1;
      chk("misq_pop_i_ready", i_ready, 0);
      chk("misq_pop_o_valid", o_valid, 1);
      chk("misq_pop_misalgn", o_misalgn, 0);
      @(negedge clk); rsp_valid = 0; #1;
      chk("misq_drained_i_ready", i_ready, 1);
      chk("misq_drained_cmd_valid", cmd_valid, 0);
      @(negedge clk); idle(); #1;
      chk("misq_exc_o_valid", o_valid, 1);
      chk("misq_exc_misalgn", o_misalgn, 1);
      @(negedge clk); idle(); #1;
      chk("misq_exc_done", o_valid, 0);
`else
      @(negedge clk); idle();
      issue(0, 1, 2'd1, 0, 32'h0, 32'h1, 32'h1234_ABCD, 5'd6); #1;
      chk("aln_hst_cmd_valid", cmd_valid, 1);
      chk("aln_hst_addr", cmd_addr, 32'h0);
      chk("aln_hst_wmask", cmd_wmask, 32'h3);
      chk("aln_hst_wdata", cmd_wdata, 32'hABCD_ABCD);
      @(negedge clk); idle(); respond(32'h0, 0); #1;
      chk("aln_hst_o_valid", o_valid, 1);
      chk("aln_hst_misalgn", o_misalgn, 0);
      chk("aln_hst_rdwen", o_rdwen, 0);
      @(negedge clk); idle();
      issue(1, 0, 2'd2, 0, 32'h100, 32'h7, 32'h0, 5'd8); #1;
      chk("aln_lw_addr", cmd_addr, 32'h104);
      @(negedge clk); idle(); respond(32'h1122_3344, 0); #1;
      chk("aln_lw_wdat", o_wdat, 32'h1122_3344);
      chk("aln_lw_misalgn", o_misalgn, 0);
`endif

      // Bus error with write-back back-pressure
      @(negedge clk); idle();
      issue(1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h0, 5'd5); #1;
      chk("berr_cmd_valid", cmd_valid, 1);
      @(negedge clk); idle(); respond(32'hFFFF_FFFF, 1); o_ready = 0; #1;
      chk("berr_o_valid", o_valid, 1);
      chk("berr_rsp_ready_stall", rsp_ready, 0);
      chk("berr_buserr", o_buserr, 1);
      chk("berr_rdwen", o_rdwen, 0);
      chk("berr_wdat", o_wdat, 0);
      @(negedge clk); #1;
      chk("berr_held_o_valid", o_valid, 1);
      chk("berr_held_buserr", o_buserr, 1);
      o_ready = 1; #1;
      chk("berr_rsp_ready", rsp_ready, 1);
      @(negedge clk); idle(); respond(32'h0, 0); #1;
      chk("berr_drained", o_valid, 0);

      // Reset with two transactions outstanding
      @(negedge clk); idle();
      issue(1, 0, 2'd2, 0, 32'h400, 32'h0, 32'h0, 5'd10);
      @(negedge clk);
      issue(1, 0, 2'd2, 0, 32'h404, 32'h0, 32'h0, 5'd11);
      @(negedge clk);
      respond(32'h5555_AAAA, 0);
      rst_n = 1'b0; #1;
      chk("mrst_o_valid", o_valid, 0);
      chk("mrst_rsp_ready", rsp_ready, 0);
      chk("mrst_cmd_valid", cmd_valid, 0);
      @(negedge clk);
      rst_n = 1'b1; #1;
      chk("mrst_rel_cmd_valid", cmd_valid, 0);
      chk("mrst_rel_o_valid", o_valid, 0);
      @(negedge clk); idle();
      issue(1, 0, 2'd2, 0, 32'h500, 32'h0, 32'h0, 5'd12); #1;
      chk("mrst_new_i_ready", i_ready, 1);
      chk("mrst_new_cmd_valid", cmd_valid, 1);
      @(negedge clk); idle(); respond(32'hCAFE_F00D, 0); #1;
      chk("mrst_new_wdat", o_wdat, 32'hCAFE_F00D);
      chk("mrst_new_rdidx", o_rdidx, 12);
      @(negedge clk); idle(); respond(32'h0, 0); #1;
      chk("mrst_empty", o_valid, 0);

      // Random traffic against the transaction model
      q.delete();
      exc_p = 0;
      for (int it = 0; it < 400; it++) begin
         @(negedge clk);
         op = $urandom_range(0, 2);
         v = ($urandom_range(0, 3) != 0);
         sz = 2'($urandom_range(0, 3));
         us = 1'($urandom);
         rs1 = $urandom; imm = $urandom; rs2 = $urandom; rd = 5'($urandom);
         cr = ($urandom_range(0, 3) != 0);
         rv = 1'($urandom);
         rdata = $urandom;
         er = ($urandom_range(0, 7) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         idle();
         if (v) issue(op == 1, op == 2, sz, us, rs1, imm, rs2, rd);
         else begin i_load = (op == 1); i_store = (op == 2); i_size = sz; end
         cmd_ready = cr; o_ready = ordy;
         rsp_valid = rv; rsp_rdata = rdata; rsp_err = er;
         #1;
         n = nbytes(sz);
         a = int'((rs1 + imm) & 32'hFFFF);
         misal = m_misal(a, n);
         off = m_addr(a, n) % 4;
         ldst = (op != 0);
         pop = rv && ordy && (q.size() > 0);
         full_eff = (q.size() == DEPTH) && !pop;
         exp_irdy = !ldst ? 1'b1 : misal ? (q.size() == 0 && !exc_p) : (cr && !full_eff && !exc_p);
         exp_cv = v && ldst && !misal && !full_eff && !exc_p;
         exp_ov = exc_p || (rv && q.size() > 0);
         if (v) chk("rnd_i_ready", i_ready, exp_irdy);
         chk("rnd_cmd_valid", cmd_valid, exp_cv);
         chk("rnd_o_valid", o_valid, exp_ov);
         chk("rnd_rsp_ready", rsp_ready, ordy && (q.size() > 0));
         if (exp_cv) begin
            chk("rnd_cmd_addr", cmd_addr, 32'(m_addr(a, n)));
            chk("rnd_cmd_read", cmd_read, op == 1);
            chk("rnd_cmd_wmask", cmd_wmask, (op == 1) ? 4'h0 : m_wmask(n, off));
            if (op == 2) chk("rnd_cmd_wdata", cmd_wdata, m_wdata(rs2, n));
         end
         if (exc_p) begin
            chk("rnd_exc_misalgn", o_misalgn, 1);
            chk("rnd_exc_rdwen", o_rdwen, 0);
            chk("rnd_exc_buserr", o_buserr, 0);
         end else if (exp_ov) begin
            t = q[0];
            rdw = t.load && !er;
            chk("rnd_rdwen", o_rdwen, rdw);
            chk("rnd_buserr", o_buserr, er);
            chk("rnd_misalgn", o_misalgn, 0);
            chk("rnd_rdidx", o_rdidx, t.rd);
            chk("rnd_wdat", o_wdat, rdw ? m_load(rdata, t.off, t.n, t.usign) : 32'h0);
         end
         if (pop) void'(q.pop_front());
         if (exp_cv && cr) begin
            t.load = (op == 1); t.n = n; t.usign = us; t.rd = rd; t.off = off;
            q.push_back(t);
         end
         if (exc_p && ordy) exc_p = 0;
         else if (v && exp_irdy && ldst && misal) exc_p = 1;
      end

      @(negedge clk); idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
